// File: rtl/popcnt_frame_ctrl_if.sv
// popcnt_frame_ctrl_if: byte-in / result-out handshake bundle for the frame popcount sequencer
interface popcnt_frame_ctrl_if #(
  parameter int CNT_W = 9,
  parameter int LEN_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic [CNT_W-1:0] thresh;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_ones;
  logic [LEN_W-1:0] res_bytes;
  logic             res_err;
  logic             res_above;
  modport master (
    output in_valid, in_data, in_last, thresh, res_ready,
    input  in_ready, res_valid, res_ones, res_bytes, res_err, res_above
  );
  modport slave (
    input  in_valid, in_data, in_last, thresh, res_ready,
    output in_ready, res_valid, res_ones, res_bytes, res_err, res_above
  );
endinterface

// File: rtl/popcnt_frame_ctrl.sv
// popcnt_frame_ctrl: per-frame set-bit counter with byte pipeline, overflow discard and threshold result
module popcnt_frame_ctrl #(
  parameter int MAX_BYTES = 32,
  parameter int CNT_W     = $clog2(MAX_BYTES*8+1),
  parameter int LEN_W     = $clog2(MAX_BYTES+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  popcnt_frame_ctrl_if.slave   bus,
  output logic                 busy
);
  typedef enum logic [1:0] {RECV, DISCARD, DRAIN, HOLD} state_t;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d, acc_in;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic             err_q, err_d;
  logic             s1_v_q, s1_v_d;
  logic [3:0]       s1_pc_q, s1_pc_d;
  logic [CNT_W-1:0] res_ones_q, res_ones_d;
  logic [LEN_W-1:0] res_bytes_q, res_bytes_d;
  logic             res_err_q, res_err_d;
  logic             res_above_q, res_above_d;
  logic             hs, first;
  // in_ready is forced low while reset is asserted, otherwise open in RECV/DISCARD
  assign bus.in_ready  = rst_n & (state_q == RECV | state_q == DISCARD);
  assign bus.res_valid = state_q == HOLD;
  assign bus.res_ones  = res_ones_q;
  assign bus.res_bytes = res_bytes_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_above = res_above_q;
  assign busy          = state_q != RECV | byte_cnt_q != '0;
  // next state, stage-1 popcount, stage-2 accumulate and result capture
  always_comb begin
    hs          = bus.in_valid & bus.in_ready;
    first       = state_q == RECV & byte_cnt_q == '0;
    acc_in      = acc_q + (s1_v_q ? CNT_W'(s1_pc_q) : '0);
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    acc_d       = acc_in;
    thresh_d    = thresh_q;
    err_d       = err_q;
    s1_v_d      = 1'b0;
    s1_pc_d     = s1_pc_q;
    res_ones_d  = res_ones_q;
    res_bytes_d = res_bytes_q;
    res_err_d   = res_err_q;
    res_above_d = res_above_q;
    case (state_q)
      RECV: if (hs) begin
        byte_cnt_d = byte_cnt_q + 1'b1;
        s1_v_d     = 1'b1;
        s1_pc_d    = 4'($countones(bus.in_data));
        if (first) begin
          thresh_d = bus.thresh;
          err_d    = 1'b0;
          acc_d    = '0;
        end
        if (bus.in_last) state_d = DRAIN;
        else if (byte_cnt_q == LEN_W'(MAX_BYTES-1)) begin
          state_d = DISCARD;
          err_d   = 1'b1;
        end
      end
      DISCARD: if (hs && bus.in_last) state_d = DRAIN;
      DRAIN: begin
        res_ones_d  = acc_in;
        res_bytes_d = byte_cnt_q;
        res_err_d   = err_q;
        res_above_d = acc_in >= thresh_q;
        state_d     = HOLD;
      end
      HOLD: if (bus.res_ready) begin
        state_d    = RECV;
        byte_cnt_d = '0;
        acc_d      = '0;
      end
      default: state_d = RECV;
    endcase
  end
  // state and datapath registers; async reset drops any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RECV;
      byte_cnt_q  <= '0;
      acc_q       <= '0;
      thresh_q    <= '0;
      err_q       <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_pc_q     <= '0;
      res_ones_q  <= '0;
      res_bytes_q <= '0;
      res_err_q   <= 1'b0;
      res_above_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      acc_q       <= acc_d;
      thresh_q    <= thresh_d;
      err_q       <= err_d;
      s1_v_q      <= s1_v_d;
      s1_pc_q     <= s1_pc_d;
      res_ones_q  <= res_ones_d;
      res_bytes_q <= res_bytes_d;
      res_err_q   <= res_err_d;
      res_above_q <= res_above_d;
    end
  end
endmodule
